// File: rtl/cgol_pkg.sv
// Shared types and helpers for the Game of Life frame engine.
// Holds the FSM state type, board size defaults and neighbour indexing.
package cgol_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    COMMIT,
    SEND
  } state_t;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  // Neighbour index: toroidal when wrap is set, otherwise -1 off-board.
  function automatic int nb_idx(
    input int i,
    input int n,
    input bit wrap
  );
    if (wrap) return (i + n) % n;
    if (i < 0 || i >= n) return -1;
    return i;
  endfunction

endpackage

// File: rtl/cgol_cell_next.sv
// Conway cell rule: next = (n==3) | (center & n==2).
// Ports: center, neighbours[7:0] in; next out. Purely combinational.
module cgol_cell_next (
  input  logic       center,
  input  logic [7:0] neighbours,
  output logic       next
);

  logic [3:0] n;

  always_comb begin
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + 4'(neighbours[i]);
    end
  end

  assign next = (n == 4'd3) | (center & (n == 4'd2));

endmodule

// File: rtl/cgol_frame_tx.sv
// Game of Life generation engine and row-by-row frame transmitter.
// Ports: load/seed/step requests, busy, wr_* valid/ready row stream, frame_done, gen_count.
module cgol_frame_tx
  import cgol_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16,
  localparam int AW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed,
  input  logic                 step,
  output logic                 busy,
  output logic                 wr_valid,
  input  logic                 wr_ready,
  output logic [AW-1:0]        wr_addr,
  output logic [COLS-1:0]      wr_data,
  output logic                 frame_done,
  output logic [GEN_W-1:0]     gen_count
);

  localparam bit WR = (WRAP != 0);
  localparam logic [AW-1:0] LAST = AW'(ROWS - 1);

  state_t state, state_d;
  logic [AW-1:0] row_idx, row_idx_d;
  logic [ROWS*COLS-1:0] board, board_d;
  logic [ROWS*COLS-1:0] next_board, next_board_d;
  logic busy_d, wr_valid_d, frame_done_d;
  logic [AW-1:0] wr_addr_d;
  logic [COLS-1:0] wr_data_d;
  logic [GEN_W-1:0] gen_d;

  logic [COLS-1:0] up_row, mid_row, dn_row, row_next;

  // Rows above/below the one under computation; zero when off-board.
  always_comb begin
    int ur, dr;
    ur = nb_idx(int'(row_idx) - 1, ROWS, WR);
    dr = nb_idx(int'(row_idx) + 1, ROWS, WR);
    up_row = '0;
    dn_row = '0;
    mid_row = board[int'(row_idx)*COLS +: COLS];
    if (ur >= 0) up_row = board[ur*COLS +: COLS];
    if (dr >= 0) dn_row = board[dr*COLS +: COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int L = nb_idx(c - 1, COLS, WR);
    localparam int R = nb_idx(c + 1, COLS, WR);
    logic lu, lm, ld, ru, rm, rd;
    logic [7:0] nb;
    if (L >= 0) begin : g_l
      assign lu = up_row[L];
      assign lm = mid_row[L];
      assign ld = dn_row[L];
    end else begin : g_nl
      assign lu = 1'b0;
      assign lm = 1'b0;
      assign ld = 1'b0;
    end
    if (R >= 0) begin : g_r
      assign ru = up_row[R];
      assign rm = mid_row[R];
      assign rd = dn_row[R];
    end else begin : g_nr
      assign ru = 1'b0;
      assign rm = 1'b0;
      assign rd = 1'b0;
    end
    assign nb = {lu, up_row[c], ru, lm, rm, ld, dn_row[c], rd};
    cgol_cell_next u_cell (
      .center     (mid_row[c]),
      .neighbours (nb),
      .next       (row_next[c])
    );
  end

  always_comb begin
    state_d      = state;
    row_idx_d    = row_idx;
    board_d      = board;
    next_board_d = next_board;
    busy_d       = busy;
    wr_valid_d   = wr_valid;
    wr_addr_d    = wr_addr;
    wr_data_d    = wr_data;
    frame_done_d = 1'b0;
    gen_d        = gen_count;
    unique case (state)
      IDLE: begin
        if (load) begin
          board_d    = seed;
          gen_d      = '0;
          state_d    = SEND;
          busy_d     = 1'b1;
          wr_valid_d = 1'b1;
          wr_addr_d  = '0;
          wr_data_d  = seed[COLS-1:0];
        end else if (step) begin
          state_d   = COMPUTE;
          row_idx_d = '0;
          busy_d    = 1'b1;
        end
      end
      COMPUTE: begin
        next_board_d[int'(row_idx)*COLS +: COLS] = row_next;
        if (row_idx == LAST) begin
          row_idx_d = '0;
          state_d   = COMMIT;
        end else begin
          row_idx_d = row_idx + 1'b1;
        end
      end
      COMMIT: begin
        board_d    = next_board;
        gen_d      = gen_count + 1'b1;
        state_d    = SEND;
        wr_valid_d = 1'b1;
        wr_addr_d  = '0;
        wr_data_d  = next_board[COLS-1:0];
      end
      SEND: begin
        if (wr_valid && wr_ready) begin
          if (wr_addr == LAST) begin
            wr_valid_d   = 1'b0;
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
          end else begin
            wr_addr_d = wr_addr + 1'b1;
            wr_data_d = board[(int'(wr_addr) + 1)*COLS +: COLS];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      row_idx    <= '0;
      board      <= '0;
      next_board <= '0;
      busy       <= 1'b0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      gen_count  <= '0;
    end else begin
      state      <= state_d;
      row_idx    <= row_idx_d;
      board      <= board_d;
      next_board <= next_board_d;
      busy       <= busy_d;
      wr_valid   <= wr_valid_d;
      wr_addr    <= wr_addr_d;
      wr_data    <= wr_data_d;
      frame_done <= frame_done_d;
      gen_count  <= gen_d;
    end
  end

endmodule

// File: doc/cgol_frame_tx.md
Name: cgol_frame_tx

Overview:
- Generation engine and frame transmitter for the 8x8 Conway's Game of Life board.
- Holds the current board and computes the next generation one row per cycle on a step request.
- Streams the board row by row over a valid/ready write interface into the LED display controller, which latches rows by address.
- Sits between the user/seed logic (load, step) and the display controller.

Parameters:
- ROWS, 8, board rows; the address width is $clog2(ROWS).
- COLS, 8, board columns; this is also the wr_data width.
- WRAP, 1, 1 = toroidal edges (neighbour indices mod ROWS/COLS); 0 = out-of-board neighbours count as dead.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- load  in  1  single-cycle request to load seed as the current board; sampled only in IDLE.
- seed  in  ROWS*COLS  initial board; bit r*COLS+c is cell (r,c).
- step  in  1  single-cycle request to advance one generation; sampled only in IDLE.
- busy  out  1  high in any state other than IDLE.
- wr_valid  out  1  a row is presented on wr_addr/wr_data.
- wr_ready  in  1  the display controller accepts the presented row.
- wr_addr  out  $clog2(ROWS)  row index being sent.
- wr_data  out  COLS  row contents; bit c is cell (r,c).
- frame_done  out  1  one-cycle pulse after the last row of a frame is accepted.
- gen_count  out  GEN_W  generations computed since the last load.

Behaviour:
- Reset (async, reset_n=0): state IDLE; board and next_board cleared; row_idx=0.
- Outputs under reset: busy=0, wr_valid=0, wr_addr=0, wr_data=0, frame_done=0, gen_count=0.
- Reset mid-frame aborts immediately; no partial commit survives.
- States: IDLE, COMPUTE, COMMIT, SEND. All outputs are registered.
- IDLE, load=1: board<=seed, gen_count<=0, then SEND with row 0 presented on the next cycle. Load takes priority over step in the same cycle.
- IDLE, step=1 (load=0): go to COMPUTE with row_idx=0.
- load/step outside IDLE: ignored; requests are not queued.
- COMPUTE: each cycle next_board[row_idx] is computed from board through the cell rule, and row_idx increments. After row ROWS-1, go to COMMIT. The board itself is unchanged during COMPUTE.
- Cell rule: n = count of the 8 live neighbours (0..8, 4-bit). next = (n==3) | (center & n==2).
- COMMIT (1 cycle): board<=next_board; gen_count<=gen_count+1, wrapping from all-ones to 0; enter SEND with wr_valid<=1, wr_addr<=0, wr_data<=board row 0 (the new board).
- SEND handshake: a transfer occurs on a rising edge where wr_valid & wr_ready.
  - Without a transfer, wr_addr and wr_data are held stable and wr_valid stays high.
  - After a transfer on row r<ROWS-1, row r+1 is presented the next cycle (back-to-back allowed).
  - After the transfer of row ROWS-1: wr_valid<=0, frame_done<=1 for exactly one cycle, state IDLE, busy<=0.
- Latency, step at edge E0 with wr_ready tied high: busy visible after E0; compute on E1..E8; commit on E9; rows accepted on E10..E17; frame_done high between E17 and E18.
- wr_ready while wr_valid=0 has no effect.

Decomposition:
- Package cgol_pkg:
  - state enum type: IDLE, COMPUTE, COMMIT, SEND.
  - default ROWS/COLS constants.
  - function wrapping a neighbour index according to WRAP.
- Sub-module cgol_cell_next:
  - combinational; inputs center and neighbours[7:0], output next.
  - instantiated COLS times for the row under computation.
- Top: FSM, row counter, board/next_board registers, output registers.

Test Plan:
1. Reset mid-SEND: load a seed, deassert reset_n while wr_valid=1 -> all outputs 0 asynchronously; on release the state is IDLE and the next step produces an all-zero frame with gen_count=1.
2. Blinker, wr_ready=1: load column 3 live in rows 2..4 -> rows 2,3,4 sent as 0x08, others 0x00, frame_done once. Then step -> row 3=0x1C, others 0x00, gen_count=1, frame_done exactly 17 cycles after the step edge.
3. Wrap (WRAP=1): load row 0 = 0x83, others 0 -> after step, rows 7,0,1 = 0x01, others 0x00.
4. Backpressure: step, then drop wr_ready for 3 cycles while row 2 is presented -> wr_addr=2 and wr_data held constant with wr_valid high; exactly 8 transfers with addresses 0..7 in order, no duplicates.
5. Still life plus ignored requests: load a 2x2 block (rows 3,4 = 0x18); pulse step, then pulse step and load again while busy -> only one generation runs; frame rows 3,4 = 0x18; gen_count=1; the second step and load have no effect.
6. Priority and counter wrap: load and step in the same IDLE cycle -> seed displayed and gen_count=0. Force gen_count to all-ones and step -> gen_count=0.
